// File: rtl/mic1_uart_rx.sv
// ---------------------------------------------------------------------------
// mic1_uart_rx
// UART receiver for the MIC-1 iCEBreaker top level. Deserialises the
// host->board serial line (8 data bits LSB first, 1 stop bit, idle high) into
// bytes and presents them to the MIC-1 input port through a valid/ready
// handshake.
//
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// after data bit 7. Without it the frame is 10 bits and parity_err is tied 0.
//
// Parameters:
//   CLK_HZ        system clock frequency
//   BAUD          line rate
//   CLKS_PER_BIT  clocks per bit period (CLK_HZ/BAUD)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ser_rx       in   serial input, asynchronous to clk, idle high
//   rx_data      out  received byte, stable while rx_valid=1
//   rx_valid     out  byte available, held until accepted
//   rx_ready     in   consumer accepts byte when rx_valid & rx_ready
//   frame_err    out  1-cycle pulse: stop bit sampled 0
//   overrun_err  out  1-cycle pulse: byte completed while previous still held
//   parity_err   out  1-cycle pulse: parity mismatch
// ---------------------------------------------------------------------------
module mic1_uart_rx #(
    parameter int CLK_HZ       = 12000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BRK    = 3'd5
    } state_t;

    // Control state
    logic             sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;

    // Output registers
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_err_q, overrun_err_d;
    logic             parity_err_q, parity_err_d;

    // Datapath (no reset needed: always written before being consumed)
    logic [7:0]       shift_q;
    logic             shift_en;
`ifdef UART_RX_PARITY_EN
    logic             par_q;
    logic             par_en;
`endif

    logic             rxs;
    logic             expired;
    logic             par_bad;
    logic             deliver;

    assign rxs     = sync2_q;
    assign expired = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits xor parity bit must be 0
    assign par_bad = ^{shift_q, par_q};
`else
    assign par_bad = 1'b0;
`endif

    // ---- Next-state logic ----
    always_comb begin
        state_d     = state_q;
        cnt_d       = expired ? cnt_q : cnt_q - 1'b1;
        idx_d       = idx_q;
        shift_en    = 1'b0;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = CNT_HALF;
                end
            end
            S_START: begin
                if (expired) begin
                    if (rxs) begin
                        state_d = S_IDLE;   // glitch: line back high mid start bit
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = CNT_FULL;
                        idx_d   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (expired) begin
                    shift_en = 1'b1;
                    cnt_d    = CNT_FULL;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (expired) begin
                    par_en  = 1'b1;
                    state_d = S_STOP;
                    cnt_d   = CNT_FULL;
                end
            end
`endif
            S_STOP: begin
                if (expired) begin
                    parity_err_d = par_bad;
                    if (!rxs) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BRK;
                    end else begin
                        deliver = !par_bad;
                        state_d = S_IDLE;
                    end
                end
            end
            S_BRK: begin
                // A held-low line must go high before a new start is accepted
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---- Output / handshake logic ----
    always_comb begin
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q & ~rx_ready;
        overrun_err_d = 1'b0;
        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;   // keep the held byte, drop the new one
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            sync1_q       <= ser_rx;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            parity_err_q  <= parity_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shift_q[idx_q] <= rxs;
`ifdef UART_RX_PARITY_EN
        if (par_en) par_q <= rxs;
`endif
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign parity_err  = parity_err_q;

endmodule
